detector_window_scheduler: RTL and testbench

// Sequences acquisition windows on the 64-bit detector hit bus. An idle hit

---
 rtl/detector_window_scheduler.sv | 131 +++++++++++++
 tb/tb_detector_window_scheduler.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/detector_window_scheduler.sv
// Detector acquisition window scheduler: opens a window on an idle hit,
// OR-accumulates hits, streams the mask out, then waits out a dead time.
module detector_window_scheduler #(
  parameter int DATA_WIDTH = 64,
  parameter int GROUPS     = 4,
  parameter int CNTR_WIDTH = 8
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [CNTR_WIDTH-1:0] cfg_window,
  input  logic [CNTR_WIDTH-1:0] cfg_holdoff,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [GROUPS-1:0]     test,
  output logic                  busy,
  output logic [31:0]           win_cnt,
  output logic [15:0]           drop_cnt
);

  localparam int GW = DATA_WIDTH / GROUPS;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_WINDOW = 2'd1;
  localparam logic [1:0] S_SEND   = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam logic [CNTR_WIDTH-1:0] C_ZERO = '0;
  localparam logic [CNTR_WIDTH-1:0] C_ONE  = 1;

  logic [1:0]            state;
  logic [1:0]            state_d;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] mask_d;
  logic [CNTR_WIDTH-1:0] cntr;
  logic [CNTR_WIDTH-1:0] cntr_d;
  logic [CNTR_WIDTH-1:0] win_lat;
  logic [CNTR_WIDTH-1:0] hold_lat;
  logic [GROUPS-1:0]     grp_or;
  logic                  hit;
  logic                  trig;
  logic                  fire;
  logic                  dead;

  assign hit  = |din;
  assign trig = (state == S_IDLE) && enable && hit;
  assign fire = m_axis_tvalid && m_axis_tready;
  assign dead = (state == S_SEND) || (state == S_HOLD);

  assign m_axis_tdata = mask;

  always_comb begin
    grp_or = '0;
    for (int g = 0; g < GROUPS; g++) begin
      grp_or[g] = |mask[g*GW +: GW];
    end
  end

  always_comb begin
    state_d = state;
    mask_d  = mask;
    cntr_d  = cntr;
    unique case (state)
      S_IDLE: begin
        if (trig) begin
          mask_d  = din;
          cntr_d  = C_ZERO;
          state_d = (cfg_window == C_ZERO) ? S_SEND : S_WINDOW;
        end
      end
      S_WINDOW: begin
        mask_d = mask | din;
        if (cntr == win_lat - C_ONE) begin
          state_d = S_SEND;
        end else begin
          cntr_d = cntr + C_ONE;
        end
      end
      S_SEND: begin
        if (fire) begin
          cntr_d  = C_ZERO;
          state_d = (hold_lat != C_ZERO) ? S_HOLD : S_IDLE;
        end
      end
      S_HOLD: begin
        if (cntr == hold_lat - C_ONE) begin
          state_d = S_IDLE;
        end else begin
          cntr_d = cntr + C_ONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= S_IDLE;
      mask          <= '0;
      cntr          <= '0;
      win_lat       <= '0;
      hold_lat      <= '0;
      m_axis_tvalid <= 1'b0;
      busy          <= 1'b0;
      test          <= '0;
      win_cnt       <= '0;
      drop_cnt      <= '0;
    end else begin
      state         <= state_d;
      mask          <= mask_d;
      cntr          <= cntr_d;
      m_axis_tvalid <= (state_d == S_SEND);
      busy          <= (state_d != S_IDLE);
      if (trig) begin
        win_lat  <= cfg_window;
        hold_lat <= cfg_holdoff;
      end
      if (fire) begin
        test    <= grp_or;
        win_cnt <= win_cnt + 32'd1;
      end
      // hits arriving while the mask is in flight or in dead time are lost
      if (dead && hit && (drop_cnt != 16'hFFFF)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_detector_window_scheduler.sv
// Scoreboard bench for detector_window_scheduler with a
// transaction-level reference model.
module tb_detector_window_scheduler;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [63:0] din;
  logic [7:0]  cfg_window;
  logic [7:0]  cfg_holdoff;
  logic [63:0] tdata;
  logic        tvalid;
  logic        tready;
  logic [3:0]  test;
  logic        busy;
  logic [31:0] win_cnt;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  bit          m_busy;
  bit          m_valid;
  logic [3:0]  m_test;
  int unsigned m_wins;
  int          m_drop;
  logic [63:0] sb_q[$];
  logic [63:0] last_beat = '0;

  detector_window_scheduler #(
    .DATA_WIDTH(64),
    .GROUPS(4),
    .CNTR_WIDTH(8)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .enable(enable),
    .din(din),
    .cfg_window(cfg_window),
    .cfg_holdoff(cfg_holdoff),
    .m_axis_tdata(tdata),
    .m_axis_tvalid(tvalid),
    .m_axis_tready(tready),
    .test(test),
    .busy(busy),
    .win_cnt(win_cnt),
    .drop_cnt(drop_cnt)
  );

  always #5 aclk = ~aclk;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [3:0] grp(logic [63:0] m);
    logic [3:0] r;
    for (int g = 0; g < 4; g++) r[g] = |m[g*16 +: 16];
    return r;
  endfunction

  task automatic m_clear();
    m_busy  = 0;
    m_valid = 0;
    m_test  = '0;
    m_wins  = 0;
    m_drop  = 0;
    sb_q.delete();
  endtask

  task automatic m_tick(output bit rst);
    @(posedge aclk);
    rst = !aresetn;
    if (rst) m_clear();
  endtask

  task automatic m_count_drop();
    if (din != 0 && m_drop < 65535) m_drop++;
  endtask

  // reference model: one window transaction at a time
  initial begin : model
    bit          rst;
    bit          done;
    logic [63:0] acc;
    int          w;
    int          h;
    m_clear();
    forever begin
      m_tick(rst);
      if (rst) continue;
      if (!(enable && din != 0)) continue;
      acc    = din;
      w      = int'(cfg_window);
      h      = int'(cfg_holdoff);
      m_busy = 1;
      for (int i = 0; i < w && !rst; i++) begin
        m_tick(rst);
        if (!rst) acc |= din;
      end
      if (rst) continue;
      sb_q.push_back(acc);
      m_valid = 1;
      done = 0;
      while (!done && !rst) begin
        m_tick(rst);
        if (!rst) begin
          m_count_drop();
          if (tready) done = 1;
        end
      end
      if (rst) continue;
      m_valid = 0;
      m_wins++;
      m_test = grp(acc);
      for (int j = 0; j < h && !rst; j++) begin
        m_tick(rst);
        if (!rst) m_count_drop();
      end
      if (rst) continue;
      m_busy = 0;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge aclk);
      if (aresetn === 1'b1) begin
        chk("busy", busy, m_busy);
        chk("tvalid", tvalid, m_valid);
        chk("test", test, m_test);
        chk("win_cnt", win_cnt, m_wins);
        chk("drop_cnt", drop_cnt, m_drop);
        if (tvalid) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL beat: got %h expected none", tdata);
          end else begin
            chk("tdata", tdata, sb_q[0]);
            if (tready) last_beat = sb_q.pop_front();
          end
        end
      end
    end
  end

  task automatic cyc(int n = 1);
    repeat (n) begin
      @(posedge aclk);
      #2;
    end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_tdata"}, tdata, 0);
    chk({tag, "_tvalid"}, tvalid, 0);
    chk({tag, "_test"}, test, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_win_cnt"}, win_cnt, 0);
    chk({tag, "_drop_cnt"}, drop_cnt, 0);
  endtask

  initial begin : stim
    aresetn     = 0;
    enable      = 0;
    din         = '0;
    cfg_window  = '0;
    cfg_holdoff = '0;
    tready      = 0;
    cyc(2);
    chk_zero("reset");
    aresetn = 1;
    cyc(1);

    enable      = 1;
    cfg_window  = 8'd3;
    cfg_holdoff = 8'd2;
    tready      = 1;
    din = 64'd1 << 50;
    cyc(1);
    din = '0;
    cyc(1);
    din = 64'd1 << 10;
    cyc(1);
    din = '0;
    cyc(10);
    chk("t1_beat", last_beat, 64'h0004_0000_0000_0400);
    chk("t1_test", test, 4'b1001);
    chk("t1_wins", win_cnt, 1);

    cfg_window  = 8'd0;
    cfg_holdoff = 8'd0;
    din = 64'd1;
    cyc(1);
    din = '0;
    chk("t2_latency", tvalid, 1);
    cyc(3);
    chk("t2_beat", last_beat, 64'd1);
    chk("t2_test", test, 4'b0001);

    tready      = 0;
    cfg_window  = 8'd2;
    cfg_holdoff = 8'd1;
    din = '1;
    cyc(3);
    cyc(5);
    chk("t3_hold_valid", tvalid, 1);
    chk("t3_drop", drop_cnt, 5);
    din    = '0;
    tready = 1;
    cyc(5);
    chk("t3_beat", last_beat, '1);
    chk("t3_wins", win_cnt, 3);

    cfg_window  = 8'd1;
    cfg_holdoff = 8'd0;
    din = 64'h8000_0000_0000_0000;
    cyc(30);
    din = '0;
    cyc(5);
    chk("t4_wins", win_cnt, 13);
    chk("t4_drop", drop_cnt, 15);

    cfg_window = 8'd5;
    din = 64'd1;
    cyc(1);
    din = '0;
    cyc(2);
    aresetn = 0;
    #1;
    chk_zero("t5_async");
    cyc(2);
    aresetn = 1;
    cyc(1);
    cfg_window = 8'd1;
    din = 64'd2;
    cyc(1);
    din = '0;
    cyc(6);
    chk("t5_wins", win_cnt, 1);
    chk("t5_beat", last_beat, 64'd2);

    enable = 0;
    din = '1;
    cyc(5);
    chk("t6_busy", busy, 0);
    chk("t6_wins", win_cnt, 1);
    enable      = 1;
    cfg_window  = 8'd4;
    cfg_holdoff = 8'd1;
    din = 64'h4;
    cyc(1);
    enable = 0;
    din = '0;
    cyc(10);
    chk("t6_wins2", win_cnt, 2);

    repeat (400) begin
      enable      = ($urandom_range(0, 3) != 0);
      din         = ($urandom_range(0, 2) == 0) ? {$urandom, $urandom} : 64'd0;
      tready      = $urandom_range(0, 1) != 0;
      cfg_window  = 8'($urandom_range(0, 6));
      cfg_holdoff = 8'($urandom_range(0, 4));
      cyc(1);
    end

    enable = 0;
    din    = '0;
    tready = 1;
    cyc(30);
    chk("sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
